// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-scheduling datapath.
package rc4_pkg;

    localparam int unsigned S_SIZE          = 256;
    localparam int unsigned DEFAULT_KEY_LEN = 3;
    localparam int unsigned MAX_KEY_LEN     = 32;
    localparam int unsigned MAX_KEY_W       = 8 * MAX_KEY_LEN;

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        LT_I,
        RD_J,
        LT_J,
        WR_I,
        WR_J,
        DONE
    } ksa_state_t;

    // Byte k of a key_len-byte key; byte 0 is the most significant byte.
    function automatic logic [7:0] key_byte(input logic [MAX_KEY_W-1:0] key,
                                            input int unsigned          key_len,
                                            input int unsigned          k);
        logic [MAX_KEY_W-1:0] shifted;
        shifted = key >> (8 * (key_len - 1 - k));
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/ksa_key_byte_sel.sv
// Key-byte selector: modulo-KEY_LEN byte index and the byte mux it drives.
module ksa_key_byte_sel
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_LEN = DEFAULT_KEY_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 advance,
    input  logic [8*KEY_LEN-1:0] key_reg,
    output logic [7:0]           key_byte_c
);

    localparam int unsigned    K_W    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(KEY_LEN - 1);

    logic [K_W-1:0] k;

    // Byte index wraps at the key length without a divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k <= '0;
        end else if (clear) begin
            k <= '0;
        end else if (advance) begin
            k <= (k == K_LAST) ? '0 : k + K_W'(1);
        end
    end

    // Current key byte feeds the j update.
    always_comb begin
        key_byte_c = key_byte(MAX_KEY_W'(key_reg), KEY_LEN, 32'(k));
    end

endmodule

// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling shuffle over a 256x8 S RAM with 1-cycle read latency.
// Outputs are registered from the next state so each state presents its own
// address/data/wren during its cycle.
module ksa_shuffle
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_LEN = DEFAULT_KEY_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [8*KEY_LEN-1:0] secret_key,
    output logic [7:0]           address,
    output logic [7:0]           data,
    output logic                 wren,
    input  logic [7:0]           q,
    output logic                 selector,
    output logic                 finish
);

    localparam int unsigned KEY_W  = 8 * KEY_LEN;
    localparam logic [7:0]  LAST_I = 8'(S_SIZE - 1);

    ksa_state_t       state;
    ksa_state_t       next_state;

    logic [7:0]       i;
    logic [7:0]       j;
    logic [7:0]       si;
    logic [7:0]       sj;
    logic [KEY_W-1:0] key_reg;

    logic [7:0]       i_nxt;
    logic [7:0]       j_nxt;
    logic [7:0]       si_nxt;
    logic [7:0]       sj_nxt;
    logic [KEY_W-1:0] key_nxt;

    logic [7:0]       address_nxt;
    logic [7:0]       data_nxt;
    logic             wren_nxt;
    logic             selector_nxt;
    logic             finish_nxt;

    logic             k_clear_c;
    logic             k_advance_c;
    logic [7:0]       key_byte_c;

    ksa_key_byte_sel #(
        .KEY_LEN    (KEY_LEN)
    ) u_key_sel (
        .clk        (clk),
        .reset      (reset),
        .clear      (k_clear_c),
        .advance    (k_advance_c),
        .key_reg    (key_reg),
        .key_byte_c (key_byte_c)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            i        <= '0;
            j        <= '0;
            si       <= '0;
            sj       <= '0;
            key_reg  <= '0;
            address  <= '0;
            data     <= '0;
            wren     <= 1'b0;
            selector <= 1'b0;
            finish   <= 1'b0;
        end else begin
            state    <= next_state;
            i        <= i_nxt;
            j        <= j_nxt;
            si       <= si_nxt;
            sj       <= sj_nxt;
            key_reg  <= key_nxt;
            address  <= address_nxt;
            data     <= data_nxt;
            wren     <= wren_nxt;
            selector <= selector_nxt;
            finish   <= finish_nxt;
        end
    end

    // Next state, datapath updates, and outputs for the state being entered.
    always_comb begin
        next_state   = state;
        i_nxt        = i;
        j_nxt        = j;
        si_nxt       = si;
        sj_nxt       = sj;
        key_nxt      = key_reg;
        k_clear_c    = 1'b0;
        k_advance_c  = 1'b0;
        address_nxt  = '0;
        data_nxt     = '0;
        wren_nxt     = 1'b0;
        selector_nxt = 1'b0;
        finish_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    key_nxt    = secret_key;
                    i_nxt      = '0;
                    j_nxt      = '0;
                    k_clear_c  = 1'b1;
                    next_state = RD_I;
                end
            end
            RD_I: next_state = LT_I;
            LT_I: begin
                si_nxt     = q;
                j_nxt      = j + q + key_byte_c;
                next_state = RD_J;
            end
            RD_J: next_state = LT_J;
            LT_J: begin
                sj_nxt     = q;
                next_state = WR_I;
            end
            WR_I: next_state = WR_J;
            WR_J: begin
                if (i == LAST_I) begin
                    next_state = DONE;
                end else begin
                    i_nxt       = i + 8'd1;
                    k_advance_c = 1'b1;
                    next_state  = RD_I;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase

        case (next_state)
            RD_I: begin
                address_nxt  = i_nxt;
                selector_nxt = 1'b1;
            end
            LT_I: begin
                address_nxt  = i;
                selector_nxt = 1'b1;
            end
            RD_J: begin
                address_nxt  = j_nxt;
                selector_nxt = 1'b1;
            end
            LT_J: begin
                address_nxt  = j;
                selector_nxt = 1'b1;
            end
            WR_I: begin
                address_nxt  = i;
                data_nxt     = sj_nxt;
                wren_nxt     = 1'b1;
                selector_nxt = 1'b1;
            end
            WR_J: begin
                address_nxt  = j;
                data_nxt     = si;
                wren_nxt     = 1'b1;
                selector_nxt = 1'b1;
            end
            DONE:    finish_nxt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/ksa_shuffle.md
Name: ksa_shuffle

Overview:
- RC4 key-scheduling (KSA) stage; runs directly after the S-array identity-fill stage has written s[i]=i into the 256x8 on-chip S RAM.
- For i = 0..255: j = j + s[i] + key[i mod KEY_LEN]; then swap s[i] and s[j].
- Owns the S RAM port while busy (selector high). The top-level mux hands the port to it after the fill stage finishes. Pulses finish when the array is permuted; the PRGA stage consumes the result.

Parameters:
- KEY_LEN, 3, secret key length in bytes.
- S_SIZE, 256, S-array depth (fixed; i/j/address are 8 bits).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- start  in  1  level/pulse; sampled only in IDLE
- secret_key  in  8*KEY_LEN  key; byte 0 = MSB byte (secret_key[8*KEY_LEN-1 -: 8])
- address  out  8  S RAM address
- data  out  8  S RAM write data
- wren  out  1  S RAM write enable
- q  in  8  S RAM read data; valid the cycle after address is clocked in (1-cycle read latency)
- selector  out  1  high while block drives the RAM port
- finish  out  1  one-cycle done pulse

Behaviour:
- Reset (async, active-low), any time including mid-run:
  - State = IDLE; i=0, j=0, key-byte index k=0; si/sj/key registers cleared.
  - address=0, data=0, wren=0, selector=0, finish=0.
- States (each one cycle unless stated):
  - IDLE: when start=1, latch secret_key into key_reg, clear i/j/k, go to RD_I. Otherwise stay.
  - RD_I: address=i, wren=0.
  - LT_I: address=i; si <= q; j <= j + q + key_reg byte k (mod 256, 8-bit wrap).
  - RD_J: address=j (updated value), wren=0.
  - LT_J: address=j; sj <= q.
  - WR_I: address=i, data=sj, wren=1.
  - WR_J: address=j, data=si, wren=1.
    - If i==255, go to DONE.
    - Else i <= i+1, k <= (k==KEY_LEN-1)?0:k+1, go to RD_I.
  - DONE: finish=1, selector=0, wren=0; next state IDLE.
- selector=1 in RD_I..WR_J, 0 in IDLE/DONE. wren=1 only in WR_I/WR_J.
- Latency: 6 cycles per i. The edge sampling start in IDLE enters RD_I. finish is high exactly 1536 cycles after that edge, for one cycle.
- i==j: the same location is read twice and written twice with the same value, so the net effect is no change (required correct).
- start while busy or in DONE: ignored. start held high: a new run begins from the IDLE after DONE.
- secret_key changes mid-run: no effect (key_reg used).
- j wraps modulo 256; i stops at 255, with no wrap past the end.
- k uses a modulo counter, with no divider.

Decomposition:
- rc4_pkg:
  - state enum ksa_state_t {IDLE, RD_I, LT_I, RD_J, LT_J, WR_I, WR_J, DONE}
  - localparams S_SIZE=256, DEFAULT_KEY_LEN=3
  - function key_byte(key, k)
- Sub-module ksa_key_byte_sel: holds the k modulo counter and the byte mux. Ports: clk, reset, clear, advance, key_reg, k-byte out.
- Top: FSM plus i/j/si/sj datapath.

Test Plan:
- Bench setup for all scenarios: S RAM model preloaded with s[i]=i.
- key 24'h010203, start: first write pair addr0<=8'h01, addr1<=8'h00 (j=1 after i=0); i=1 read yields j=1+0+2=3.
- key 24'h000000: i=0 writes addr0<=0 twice (i==j). i=1 j=1, no-op writes. i=2 j=3: writes addr2<=3, addr3<=2.
- Full run, random key: final RAM equals golden C/Python KSA, and is a permutation of 0..255. finish pulses once, exactly 1536 cycles after the start edge. selector falls in the same cycle finish rises.
- start re-asserted mid-run and secret_key toggled mid-run: result identical to the undisturbed run; single finish pulse.
- reset low at i=100 during WR_I: outputs 0 immediately (async), state IDLE. A new start then gives the golden result from a fresh preload.
- Back-to-back: start held high. The second run begins the cycle after DONE, with a second finish at +1537 cycles.
